fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Parametrised, runtime-sized bit-reversal reorder stage that sits on the output of the pipelined FFT chain.
- It replaces the fixed bit-reversal stub after the last butterfly stage. FFT results arrive in bit-reversed order and leave in natural order.
- Double-buffered RAM: one bank fills in arrival order while the other drains at bit-reversed addresses, one sample per i_ce.
- Adds a per-frame size selection (2^LGMIN..2^LGMAX points), explicit output validity and error flagging.

Parameters:
- DW, 32, sample width in bits (complex {re,im} packed, treated as opaque).
- LGMAX, 10, log2 of largest supported frame; buffer depth is 2*2^LGMAX.
- LGMIN, 2, log2 of smallest supported frame.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_ce  in  1  clock enable; one input accepted and one output step taken per cycle with i_ce=1.
- i_sync  in  1  marks first sample of an input frame (qualified by i_ce).
- i_lgsize  in  4  log2 frame size; sampled only with i_ce&&i_sync.
- i_sample  in  DW  input sample.
- o_result  out  DW  reordered output sample (registered).
- o_sync  out  1  high with output position 0 of each frame.
- o_valid  out  1  o_result holds frame data.
- o_err  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset (async): o_result=0, o_sync=0, o_valid=0, o_err=0. Write FSM=IDLE, read FSM=EMPTY, bank pointer=0. RAM contents are don't-care.
- Nothing changes on cycles with i_ce=0, except reset and the clearing of o_err. o_err is never held beyond one i_clk cycle.
- Write FSM, state IDLE:
  - i_ce&&i_sync with LGMIN<=i_lgsize<=LGMAX: latch N=2^i_lgsize, write the sample to index 0 of the write bank, go to FILL (widx=1).
  - i_lgsize out of range: pulse o_err, stay IDLE.
  - Samples without i_sync are discarded.
- Write FSM, state FILL: each i_ce writes i_sample to mem[bank][widx] and increments widx.
  - After writing index N-1: the bank is complete. Hand the bank and its N to the read side, toggle the write bank, and go to IDLE.
  - The next frame's i_sync may arrive on the very next i_ce (contiguous frames), giving zero gap.
- Mid-frame i_sync (FILL, widx!=0): pulse o_err, discard the partial frame, and restart at index 0 of the same bank with the newly sampled size (same legality check as IDLE).
- Read FSM, state EMPTY: when a completed bank is handed over, go to DRAIN with ridx=0 and Nr=that frame's N.
- Read FSM, state DRAIN: each i_ce:
  - o_result <= mem[rbank][bitrev_lgNr(ridx)], reversing only the low log2(Nr) bits.
  - o_valid <= 1; o_sync <= (ridx==0); ridx increments.
  - After ridx=Nr-1, if another bank completed on or before this step, continue directly into it (ridx=0, new Nr). Otherwise go to EMPTY.
  - In EMPTY, each i_ce sets o_valid=0 and o_sync=0.
- Latency: if index 0 of a frame is written on i_ce step s, output position j appears on o_result after the edge of step s+N+j. For contiguous frames the output is gap-free.
- Size change: a completed frame whose N differs from the frame being drained aborts the drain on the handover step. On that step:
  - o_valid=0 and o_err is pulsed.
  - The new bank begins draining on the next i_ce.
  - No bank is ever written while it is being read.
- Reset mid-operation: all frames in flight are lost, and outputs return to their reset values immediately.

Test Plan:
- N=8 (i_lgsize=3), i_ce=1 continuous, samples 0..7 with i_sync on 0 -> after 8 steps o_result=0,4,2,6,1,5,3,7, o_sync only with first 0, o_valid=1 for all eight, then o_valid=0.
- Three contiguous N=16 frames (values 0..47) -> 48 consecutive valid outputs, o_sync at outputs 0,16,32; output 17 = 24 (16+bitrev4(1)=16+8).
- Same as the first test with i_ce toggling 1,0,1,0 -> identical output sequence; o_result/o_sync/o_valid hold on i_ce=0 cycles.
- i_sync reasserted at index 5 of an N=8 frame -> o_err one pulse, partial frame never output, restarted frame output correctly 8 steps later.
- i_lgsize=1 and i_lgsize=11 with i_sync -> o_err pulse each, no outputs; then an N=1024 frame of 0..1023 -> output position 1 = 512, position 1023 = 1023.
- Reset asserted asynchronously mid-drain of an N=32 frame -> o_valid/o_sync/o_result go to 0 without waiting for a clock edge; the next legal frame outputs normally.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversal reorder after the FFT pipeline: ping-pong RAM, one bank fills in arrival
// order while the other drains at bit-reversed addresses; frame size chosen per i_sync.
module fft_bitrev_reorder #(
  parameter int DW    = 32,
  parameter int LGMAX = 10,
  parameter int LGMIN = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_sync,
  input  logic [3:0]    i_lgsize,
  input  logic [DW-1:0] i_sample,
  output logic [DW-1:0] o_result,
  output logic          o_sync,
  output logic          o_valid,
  output logic          o_err
);
  localparam int AW = LGMAX + 1;

  typedef enum logic {W_IDLE, W_FILL}  wstate_t;
  typedef enum logic {R_EMPTY, R_DRAIN} rstate_t;

  logic [DW-1:0] mem [0:(2**AW)-1];

  wstate_t          wstate_q, wstate_d;
  logic             wbank_q, wbank_d;
  logic [LGMAX-1:0] widx_q, widx_d;
  logic [3:0]       wlg_q, wlg_d;

  rstate_t          rstate_q, rstate_d;
  logic             rbank_q, rbank_d;
  logic [LGMAX-1:0] ridx_q, ridx_d;
  logic [3:0]       rlg_q, rlg_d;

  logic [DW-1:0]    result_q, result_d;
  logic             sync_q, sync_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    mem_raddr;
  logic             lg_ok;
  logic             wdone;
  logic             werr;
  logic             rerr;
  logic             rlast;

  function automatic logic [LGMAX-1:0] last_idx(input logic [3:0] lg);
    return {LGMAX{1'b1}} >> (LGMAX - int'(lg));
  endfunction

  // Reverse the full index, then shift so only the low lg bits remain reversed.
  function automatic logic [LGMAX-1:0] bitrev(input logic [LGMAX-1:0] idx,
                                              input logic [3:0] lg);
    logic [LGMAX-1:0] r;
    for (int b = 0; b < LGMAX; b++) r[b] = idx[LGMAX-1-b];
    return r >> (LGMAX - int'(lg));
  endfunction

  assign lg_ok     = (int'(i_lgsize) >= LGMIN) && (int'(i_lgsize) <= LGMAX);
  assign rlast     = (ridx_q == last_idx(rlg_q));
  assign mem_raddr = {rbank_q, bitrev(ridx_q, rlg_q)};

  always_comb begin
    wstate_d  = wstate_q;
    wbank_d   = wbank_q;
    widx_d    = widx_q;
    wlg_d     = wlg_q;
    mem_we    = 1'b0;
    mem_waddr = {wbank_q, widx_q};
    wdone     = 1'b0;
    werr      = 1'b0;
    if (i_ce) begin
      if (i_sync) begin
        // A sync inside FILL is always mid-frame: the partial frame is dropped.
        werr = (wstate_q == W_FILL) || !lg_ok;
        if (lg_ok) begin
          mem_we    = 1'b1;
          mem_waddr = {wbank_q, {LGMAX{1'b0}}};
          wlg_d     = i_lgsize;
          widx_d    = LGMAX'(1);
          wstate_d  = W_FILL;
        end else begin
          wstate_d  = W_IDLE;
        end
      end else if (wstate_q == W_FILL) begin
        mem_we = 1'b1;
        widx_d = widx_q + LGMAX'(1);
        if (widx_q == last_idx(wlg_q)) begin
          wdone    = 1'b1;
          wbank_d  = ~wbank_q;
          wstate_d = W_IDLE;
        end
      end
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    rbank_d  = rbank_q;
    ridx_d   = ridx_q;
    rlg_d    = rlg_q;
    result_d = result_q;
    sync_d   = sync_q;
    valid_d  = valid_q;
    rerr     = 1'b0;
    if (i_ce) begin
      case (rstate_q)
        R_EMPTY: begin
          valid_d = 1'b0;
          sync_d  = 1'b0;
          if (wdone) begin
            rstate_d = R_DRAIN;
            rbank_d  = wbank_q;
            rlg_d    = wlg_q;
            ridx_d   = '0;
          end
        end
        R_DRAIN: begin
          if (wdone && (wlg_q != rlg_q) && !rlast) begin
            valid_d = 1'b0;
            sync_d  = 1'b0;
            rerr    = 1'b1;
            rbank_d = wbank_q;
            rlg_d   = wlg_q;
            ridx_d  = '0;
          end else begin
            result_d = mem[mem_raddr];
            valid_d  = 1'b1;
            sync_d   = (ridx_q == '0);
            ridx_d   = ridx_q + LGMAX'(1);
            if (rlast) begin
              if (wdone) begin
                rbank_d = wbank_q;
                rlg_d   = wlg_q;
                ridx_d  = '0;
              end else begin
                rstate_d = R_EMPTY;
              end
            end
          end
        end
        default: rstate_d = R_EMPTY;
      endcase
    end
    err_d = werr || rerr;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wstate_q <= W_IDLE;
      wbank_q  <= 1'b0;
      widx_q   <= '0;
      wlg_q    <= '0;
      rstate_q <= R_EMPTY;
      rbank_q  <= 1'b0;
      ridx_q   <= '0;
      rlg_q    <= '0;
      result_q <= '0;
      sync_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      wbank_q  <= wbank_d;
      widx_q   <= widx_d;
      wlg_q    <= wlg_d;
      rstate_q <= rstate_d;
      rbank_q  <= rbank_d;
      ridx_q   <= ridx_d;
      rlg_q    <= rlg_d;
      result_q <= result_d;
      sync_q   <= sync_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= i_sample;
  end

  assign o_result = result_q;
  assign o_sync   = sync_q;
  assign o_valid  = valid_q;
  assign o_err    = err_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: frame-level reference model indexed by i_ce step.
module tb_fft_bitrev_reorder;
  localparam int DW = 32;
  localparam int LGMAX = 10;
  localparam int MAXT = 4096;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_ce;
  logic          i_sync;
  logic [3:0]    i_lgsize;
  logic [DW-1:0] i_sample;
  logic [DW-1:0] o_result;
  logic          o_sync;
  logic          o_valid;
  logic          o_err;

  fft_bitrev_reorder #(.DW(DW), .LGMAX(LGMAX), .LGMIN(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_sync(i_sync),
    .i_lgsize(i_lgsize), .i_sample(i_sample), .o_result(o_result),
    .o_sync(o_sync), .o_valid(o_valid), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit            ce;
    bit            sync;
    logic [3:0]    lg;
    logic [DW-1:0] smp;
  } stim_t;

  stim_t         sq[$];
  int            nce;
  logic [DW-1:0] ev_d [MAXT];
  bit            ev_v [MAXT];
  bit            ev_s [MAXT];
  bit            ev_e [MAXT];
  logic [DW-1:0] ob_d [MAXT];
  logic          ob_v [MAXT];
  logic          ob_s [MAXT];
  logic          ob_e [MAXT];
  bit            have_prev;
  int            prev_s, prev_n;
  int            hold_bad, err_cnt, err_long;
  int            total = 0;
  int            bad = 0;

  function automatic int brev(input int j, input int lg);
    int r = 0;
    for (int b = 0; b < lg; b++) r = r * 2 + ((j >> b) & 1);
    return r;
  endfunction

  task automatic reset_model();
    sq.delete();
    nce = 0;
    have_prev = 0;
    for (int t = 0; t < MAXT; t++) begin
      ev_v[t] = 0; ev_s[t] = 0; ev_e[t] = 0; ev_d[t] = '0;
    end
  endtask

  task automatic reset_dut();
    i_reset = 1'b1; i_ce = 1'b0; i_sync = 1'b0; i_lgsize = '0; i_sample = '0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
  endtask

  task automatic push_step(input bit ce, input bit sync, input int lg, input logic [DW-1:0] smp);
    stim_t s;
    s.ce = ce; s.sync = sync; s.lg = 4'(lg); s.smp = smp;
    sq.push_back(s);
    if (ce) nce++;
  endtask

  task automatic push_idle(input int k, input int gap_pct);
    for (int i = 0; i < k; i++) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) push_step(0, 0, 0, $urandom);
      push_step(1, 0, 0, $urandom);
    end
  endtask

  // A legal frame: index 0 at ce-step s, output j at ce-step s+N+j. A smaller/other-size
  // frame completing inside the previous frame's drain (not on its last step) cuts it off.
  task automatic push_frame(input int lg, input int gap_pct, input bit seq, input int base);
    int n = 1 << lg;
    int s = nce;
    int c = nce + n - 1;
    logic [DW-1:0] d[$];
    for (int j = 0; j < n; j++) begin
      logic [DW-1:0] v = seq ? DW'(base + j) : DW'($urandom);
      d.push_back(v);
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) push_step(0, 0, lg, $urandom);
      push_step(1, j == 0, lg, v);
    end
    if (have_prev && n != prev_n && c >= prev_s + prev_n && c < prev_s + 2 * prev_n - 1) begin
      for (int t = c; t < prev_s + 2 * prev_n; t++) begin
        ev_v[t] = 0; ev_s[t] = 0;
      end
      ev_e[c] = 1;
    end
    for (int j = 0; j < n; j++) begin
      ev_v[s + n + j] = 1;
      ev_s[s + n + j] = (j == 0);
      ev_d[s + n + j] = d[brev(j, lg)];
    end
    have_prev = 1; prev_s = s; prev_n = n;
  endtask

  task automatic play();
    int t = 0;
    logic [DW-1:0] pr;
    logic pv, ps, pe;
    pr = o_result; pv = o_valid; ps = o_sync; pe = o_err;
    hold_bad = 0; err_cnt = 0; err_long = 0;
    foreach (sq[k]) begin
      i_ce = sq[k].ce; i_sync = sq[k].sync; i_lgsize = sq[k].lg; i_sample = sq[k].smp;
      @(posedge i_clk);
      #1;
      if (sq[k].ce) begin
        ob_v[t] = o_valid; ob_s[t] = o_sync; ob_d[t] = o_result; ob_e[t] = o_err;
        t++;
      end else if (o_valid !== pv || o_sync !== ps || o_result !== pr) begin
        hold_bad++;
      end
      if (o_err === 1'b1) begin
        err_cnt++;
        if (pe === 1'b1) err_long++;
      end
      pr = o_result; pv = o_valid; ps = o_sync; pe = o_err;
    end
    i_ce = 1'b0; i_sync = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_ce = 1'b0; i_sync = 1'b0; i_lgsize = '0; i_sample = '0;
    #2;
    total++; if (o_result !== '0) begin bad++; $display("FAIL reset o_result got=%h want=0", o_result); end
    total++; if (o_sync !== 1'b0) begin bad++; $display("FAIL reset o_sync got=%b want=0", o_sync); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset o_valid got=%b want=0", o_valid); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset o_err got=%b want=0", o_err); end
    reset_dut();
  endtask

  task automatic test_basic_n8();
    logic [DW-1:0] ref8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    reset_dut(); reset_model();
    push_frame(3, 0, 1, 0);
    push_idle(10, 0);
    play();
    for (int t = 0; t < nce; t++) begin
      total++; if (ob_v[t] !== ev_v[t]) begin bad++; $display("FAIL n8 valid t=%0d got=%b want=%b", t, ob_v[t], ev_v[t]); end
      total++; if (ob_s[t] !== ev_s[t]) begin bad++; $display("FAIL n8 sync t=%0d got=%b want=%b", t, ob_s[t], ev_s[t]); end
      total++; if (ob_e[t] !== ev_e[t]) begin bad++; $display("FAIL n8 err t=%0d got=%b want=%b", t, ob_e[t], ev_e[t]); end
      if (ev_v[t]) begin
        total++; if (ob_d[t] !== ev_d[t]) begin bad++; $display("FAIL n8 data t=%0d got=%h want=%h", t, ob_d[t], ev_d[t]); end
      end
    end
    for (int j = 0; j < 8; j++) begin
      total++; if (ob_d[8 + j] !== ref8[j]) begin bad++; $display("FAIL n8 order pos=%0d got=%0d want=%0d", j, ob_d[8 + j], ref8[j]); end
    end
  endtask

  task automatic test_back_to_back();
    int run = 0;
    reset_dut(); reset_model();
    push_frame(4, 0, 1, 0);
    push_frame(4, 0, 1, 16);
    push_frame(4, 0, 1, 32);
    push_idle(20, 0);
    play();
    for (int t = 0; t < nce; t++) begin
      total++; if (ob_v[t] !== ev_v[t]) begin bad++; $display("FAIL b2b valid t=%0d got=%b want=%b", t, ob_v[t], ev_v[t]); end
      total++; if (ob_s[t] !== ev_s[t]) begin bad++; $display("FAIL b2b sync t=%0d got=%b want=%b", t, ob_s[t], ev_s[t]); end
      if (ev_v[t]) begin
        total++; if (ob_d[t] !== ev_d[t]) begin bad++; $display("FAIL b2b data t=%0d got=%h want=%h", t, ob_d[t], ev_d[t]); end
      end
    end
    for (int t = 16; t < 64; t++) if (ob_v[t] === 1'b1) run++;
    total++; if (run !== 48) begin bad++; $display("FAIL b2b run got=%0d want=48", run); end
    total++; if (ob_d[16 + 17] !== 24) begin bad++; $display("FAIL b2b out17 got=%0d want=24", ob_d[33]); end
  endtask

  task automatic test_ce_gaps();
    reset_dut(); reset_model();
    push_frame(3, 100, 1, 0);
    push_idle(10, 100);
    play();
    for (int t = 0; t < nce; t++) begin
      total++; if (ob_v[t] !== ev_v[t]) begin bad++; $display("FAIL gaps valid t=%0d got=%b want=%b", t, ob_v[t], ev_v[t]); end
      total++; if (ob_s[t] !== ev_s[t]) begin bad++; $display("FAIL gaps sync t=%0d got=%b want=%b", t, ob_s[t], ev_s[t]); end
      if (ev_v[t]) begin
        total++; if (ob_d[t] !== ev_d[t]) begin bad++; $display("FAIL gaps data t=%0d got=%h want=%h", t, ob_d[t], ev_d[t]); end
      end
    end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL gaps hold changes got=%0d want=0", hold_bad); end
  endtask

  task automatic test_midframe_sync();
    reset_dut(); reset_model();
    push_step(1, 1, 3, 900);
    for (int j = 1; j < 5; j++) push_step(1, 0, 3, DW'(900 + j));
    ev_e[nce] = 1;
    push_frame(3, 0, 1, 50);
    push_idle(12, 0);
    play();
    for (int t = 0; t < nce; t++) begin
      total++; if (ob_v[t] !== ev_v[t]) begin bad++; $display("FAIL midsync valid t=%0d got=%b want=%b", t, ob_v[t], ev_v[t]); end
      total++; if (ob_e[t] !== ev_e[t]) begin bad++; $display("FAIL midsync err t=%0d got=%b want=%b", t, ob_e[t], ev_e[t]); end
      if (ev_v[t]) begin
        total++; if (ob_d[t] !== ev_d[t]) begin bad++; $display("FAIL midsync data t=%0d got=%h want=%h", t, ob_d[t], ev_d[t]); end
      end
    end
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL midsync err pulses got=%0d want=1", err_cnt); end
  endtask

  task automatic test_bad_size_and_max();
    reset_dut(); reset_model();
    ev_e[nce] = 1; push_step(1, 1, 1, 7);
    push_step(0, 0, 0, 0); push_step(0, 0, 0, 0);
    ev_e[nce] = 1; push_step(1, 1, 11, 7);
    push_step(0, 0, 0, 0);
    push_frame(10, 0, 1, 0);
    push_idle(1030, 0);
    play();
    for (int t = 0; t < nce; t++) begin
      total++; if (ob_v[t] !== ev_v[t]) begin bad++; $display("FAIL badsz valid t=%0d got=%b want=%b", t, ob_v[t], ev_v[t]); end
      total++; if (ob_e[t] !== ev_e[t]) begin bad++; $display("FAIL badsz err t=%0d got=%b want=%b", t, ob_e[t], ev_e[t]); end
      if (ev_v[t]) begin
        total++; if (ob_d[t] !== ev_d[t]) begin bad++; $display("FAIL badsz data t=%0d got=%h want=%h", t, ob_d[t], ev_d[t]); end
      end
    end
    total++; if (ob_d[2 + 1024 + 1] !== 512) begin bad++; $display("FAIL badsz pos1 got=%0d want=512", ob_d[1027]); end
    total++; if (ob_d[2 + 1024 + 1023] !== 1023) begin bad++; $display("FAIL badsz pos1023 got=%0d want=1023", ob_d[2049]); end
    total++; if (err_cnt !== 2) begin bad++; $display("FAIL badsz err pulses got=%0d want=2", err_cnt); end
    total++; if (err_long !== 0) begin bad++; $display("FAIL badsz err held got=%0d want=0", err_long); end
  endtask

  task automatic test_size_change();
    reset_dut(); reset_model();
    push_frame(4, 0, 1, 0);
    push_frame(2, 0, 1, 100);
    push_frame(3, 0, 1, 200);
    push_idle(12, 0);
    play();
    for (int t = 0; t < nce; t++) begin
      total++; if (ob_v[t] !== ev_v[t]) begin bad++; $display("FAIL sizechg valid t=%0d got=%b want=%b", t, ob_v[t], ev_v[t]); end
      total++; if (ob_s[t] !== ev_s[t]) begin bad++; $display("FAIL sizechg sync t=%0d got=%b want=%b", t, ob_s[t], ev_s[t]); end
      total++; if (ob_e[t] !== ev_e[t]) begin bad++; $display("FAIL sizechg err t=%0d got=%b want=%b", t, ob_e[t], ev_e[t]); end
      if (ev_v[t]) begin
        total++; if (ob_d[t] !== ev_d[t]) begin bad++; $display("FAIL sizechg data t=%0d got=%h want=%h", t, ob_d[t], ev_d[t]); end
      end
    end
  endtask

  task automatic test_random();
    reset_dut(); reset_model();
    for (int f = 0; f < 12; f++) begin
      push_idle(int'($urandom_range(0, 2)), 30);
      push_frame(int'($urandom_range(2, 5)), 30, 0, 0);
    end
    push_idle(40, 30);
    play();
    for (int t = 0; t < nce; t++) begin
      total++; if (ob_v[t] !== ev_v[t]) begin bad++; $display("FAIL rand valid t=%0d got=%b want=%b", t, ob_v[t], ev_v[t]); end
      total++; if (ob_s[t] !== ev_s[t]) begin bad++; $display("FAIL rand sync t=%0d got=%b want=%b", t, ob_s[t], ev_s[t]); end
      total++; if (ob_e[t] !== ev_e[t]) begin bad++; $display("FAIL rand err t=%0d got=%b want=%b", t, ob_e[t], ev_e[t]); end
      if (ev_v[t]) begin
        total++; if (ob_d[t] !== ev_d[t]) begin bad++; $display("FAIL rand data t=%0d got=%h want=%h", t, ob_d[t], ev_d[t]); end
      end
    end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL rand hold changes got=%0d want=0", hold_bad); end
  endtask

  task automatic test_async_reset();
    reset_dut(); reset_model();
    push_frame(5, 0, 1, 100);
    push_idle(10, 0);
    play();
    total++; if (o_valid !== ev_v[nce-1]) begin bad++; $display("FAIL arst pre valid got=%b want=%b", o_valid, ev_v[nce-1]); end
    #2 i_reset = 1'b1;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL arst valid got=%b want=0", o_valid); end
    total++; if (o_sync !== 1'b0) begin bad++; $display("FAIL arst sync got=%b want=0", o_sync); end
    total++; if (o_result !== '0) begin bad++; $display("FAIL arst result got=%h want=0", o_result); end
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    reset_model();
    push_frame(2, 0, 0, 0);
    push_idle(8, 0);
    play();
    for (int t = 0; t < nce; t++) begin
      total++; if (ob_v[t] !== ev_v[t]) begin bad++; $display("FAIL arst2 valid t=%0d got=%b want=%b", t, ob_v[t], ev_v[t]); end
      total++; if (ob_s[t] !== ev_s[t]) begin bad++; $display("FAIL arst2 sync t=%0d got=%b want=%b", t, ob_s[t], ev_s[t]); end
      if (ev_v[t]) begin
        total++; if (ob_d[t] !== ev_d[t]) begin bad++; $display("FAIL arst2 data t=%0d got=%h want=%h", t, ob_d[t], ev_d[t]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_n8();
    test_back_to_back();
    test_ce_gaps();
    test_midframe_sync();
    test_bad_size_and_max();
    test_size_change();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
